// File: rtl/memory_unit.sv
// memory_unit: word-organised data memory with clocked stores and combinational loads
module memory_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic                  clk,
    input  logic                  rst
);
    localparam int IW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]         index;
    logic                  unused_bits;

    assign index       = address[IW+1:2];
    assign unused_bits = ^{address[1:0], address[ADDR_WIDTH-1:IW+2]};

    // Reset wipes every word and takes priority over a store on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (MemWrite) begin
            mem[index] <= write_data;
        end
    end

    // Load is combinational so write-back sees the word in the same cycle
    always_comb read_data = (MemRead && !rst) ? mem[index] : '0;
endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: directed self-checking bench for memory_unit
module tb_memory_unit;
    logic        clk = 0;
    logic        rst;
    logic [31:0] read_data;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        MemWrite;
    logic        MemRead;
    int          n_checks = 0;
    int          n_fail   = 0;

    memory_unit dut (
        .read_data (read_data),
        .address   (address),
        .write_data(write_data),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .clk       (clk),
        .rst       (rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address    = a;
        write_data = d;
        MemWrite   = 1;
        MemRead    = 0;
        @(posedge clk);
        #1 MemWrite = 0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        address = a;
        MemRead = 1;
        #1 check(tag, read_data, exp);
    endtask

    initial begin
        rst        = 1;
        address    = 0;
        write_data = 0;
        MemWrite   = 0;
        MemRead    = 1;
        #1 check("read_in_reset", read_data, 32'h0);
        @(posedge clk);
        #1 rst = 0;
        rd("reset_0x0", 32'h0, 32'h0);
        rd("reset_0x4", 32'h4, 32'h0);
        rd("reset_0xFC", 32'hFC, 32'h0);
        wr(32'h4, 32'h11);
        rd("wr_rd_0x4", 32'h4, 32'h11);
        wr(32'h8, 32'h2);
        wr(32'hC, 32'h3);
        rd("word_0xC", 32'hC, 32'h3);
        rd("word_0x8", 32'h8, 32'h2);
        rd("word_0x4_kept", 32'h4, 32'h11);
        address = 32'h4;
        MemRead = 0;
        #1 check("read_gated", read_data, 32'h0);
        rd("offset_0x5", 32'h5, 32'h11);
        rd("offset_0x7", 32'h7, 32'h11);
        address    = 32'h8;
        write_data = 32'hDEADBEEF;
        MemRead    = 1;
        MemWrite   = 1;
        #1 check("rw_before_edge", read_data, 32'h2);
        @(posedge clk);
        #1 check("rw_after_edge", read_data, 32'hDEADBEEF);
        MemWrite = 0;
        wr(32'h104, 32'hA5);
        rd("alias_0x4", 32'h4, 32'hA5);
        rd("alias_0x104", 32'h104, 32'hA5);
        wr(32'hFC, 32'h5A5A5A5A);
        rd("last_word", 32'hFC, 32'h5A5A5A5A);
        rd("last_alias", 32'h1FC, 32'h5A5A5A5A);
        rd("first_word_clear", 32'h0, 32'h0);
        address    = 32'h4;
        write_data = 32'h77;
        MemWrite   = 1;
        MemRead    = 1;
        rst        = 1;
        #1 check("read_zero_in_rst", read_data, 32'h0);
        @(posedge clk);
        #1 rst = 0;
        MemWrite = 0;
        rd("rst_override_0x4", 32'h4, 32'h0);
        rd("rst_lost_0x8", 32'h8, 32'h0);
        rd("rst_lost_0xFC", 32'hFC, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_unit.md
# memory_unit

Word-organised data memory for the RISC datapath's memory stage. Byte addresses from the ALU select a 32-bit word. A store writes that word on the rising clock edge. A load returns it combinationally, so the write-back stage sees it in the same cycle. Synchronous active-high reset clears the whole array.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 32, byte-address width
- DEPTH, 64, number of words; power of two, at least 2

Ports (clock and reset first):
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset, synchronous and active-high; clears every word to 0
- read_data  output  DATA_WIDTH  load data; combinational
- address  input  ADDR_WIDTH  byte address
- write_data  input  DATA_WIDTH  store data
- MemWrite  input  1  store enable, sampled at the rising edge
- MemRead  input  1  load enable, combinational

Positional port order is fixed as read_data, address, write_data, MemWrite, MemRead, clk, rst. Existing positional instantiations depend on it.

## Operation
- Word index = address[log2(DEPTH)+1 : 2].
- address[1:0] is ignored; all accesses are full-word and word-aligned.
- Address bits above the index field are ignored, so addresses alias modulo DEPTH*4 bytes.
- Store: at a rising edge with rst=0 and MemWrite=1, mem[index] <= write_data.
- Load: read_data = mem[index] when MemRead=1 and rst=0; otherwise read_data = 0.
- Reset: at a rising edge with rst=1, every mem word <= 0. Reset overrides a simultaneous store.
- MemRead=1 and MemWrite=1 together is legal:
  - before the edge, read_data shows the old word;
  - after the edge, it shows the newly written word.
- MemWrite=0 and MemRead=0: no state change; read_data = 0.
- Unknown or X control inputs are not required to be handled; the bench drives known values after reset.

## Timing
- Write latency: one edge. Data present at edge N is readable immediately after edge N.
- Read latency: zero cycles. read_data follows address and MemRead combinationally, with no clock dependency.
- Reset value of read_data: 0 while rst=1.
- After reset is released, every word reads 0 until written.
- Reset asserted mid-sequence:
  - all earlier stores are lost at that edge;
  - a store presented on the same edge is discarded.
- No handshake; the memory is always ready.

## Test plan
- Reset clear: assert rst for one edge, release, set MemRead=1 at addresses 0x0, 0x4, 0xFC -> read_data = 0x00000000 at each.
- Write then read: address 0x4, write_data 0x11, MemWrite=1 for one edge, then MemRead=1 -> read_data = 0x00000011.
- Independent words:
  - write 0x8 <- 0x2, then 0xC <- 0x3;
  - read 0xC -> 0x3, read 0x8 -> 0x2, read 0x4 -> 0x11 (earlier word unchanged).
- Read gating and byte offset:
  - MemRead=0 at address 0x4 -> read_data = 0;
  - MemRead=1 at address 0x5 or 0x7 -> 0x11 (low bits ignored).
- Simultaneous access: address 0x8, write_data 0xDEADBEEF, MemRead=1 and MemWrite=1 -> read_data = 0x2 before the edge, 0xDEADBEEF after it.
- Aliasing and reset override:
  - with DEPTH=64, write 0x104 <- 0xA5 -> read 0x4 = 0xA5;
  - rst=1 together with MemWrite=1 at 0x4, value 0x77 -> read 0x4 = 0 after release.
